// File: rtl/mpu6050_pkg.sv
// Purpose : shared register map constants, target FSM state type and read-map helper.
// Latency : n/a (package, no logic).
// Backpr. : n/a.
package mpu6050_pkg;

  localparam logic [7:0] REG_GYRO_XOUT_H = 8'h43;
  localparam logic [7:0] REG_GYRO_XOUT_L = 8'h44;
  localparam logic [7:0] REG_GYRO_YOUT_H = 8'h45;
  localparam logic [7:0] REG_GYRO_YOUT_L = 8'h46;
  localparam logic [7:0] REG_GYRO_ZOUT_H = 8'h47;
  localparam logic [7:0] REG_GYRO_ZOUT_L = 8'h48;
  localparam logic [7:0] REG_PWR_MGMT_1  = 8'h6B;
  localparam logic [7:0] REG_WHO_AM_I    = 8'h75;
  localparam logic [7:0] PWR_MGMT_1_RST  = 8'h40;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    REG,
    REG_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    WAIT_STOP
  } i2c_tgt_state_t;

  // Read map: gyro is {XH,XL,YH,YL,ZH,ZL}; unmapped addresses read as zero.
  function automatic logic [7:0] reg_read(input logic [7:0]  addr,
                                          input logic [47:0] gyro,
                                          input logic [7:0]  pwr,
                                          input logic [7:0]  who);
    logic [7:0] val;
    case (addr)
      REG_GYRO_XOUT_H: val = gyro[47:40];
      REG_GYRO_XOUT_L: val = gyro[39:32];
      REG_GYRO_YOUT_H: val = gyro[31:24];
      REG_GYRO_YOUT_L: val = gyro[23:16];
      REG_GYRO_ZOUT_H: val = gyro[15:8];
      REG_GYRO_ZOUT_L: val = gyro[7:0];
      REG_PWR_MGMT_1:  val = pwr;
      REG_WHO_AM_I:    val = who;
      default:         val = 8'h00;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/mpu6050_i2c_target_bus_monitor.sv
// Purpose : synchronise SCL/SDA into clk and flag SCL edges, START and STOP as 1-cycle pulses.
// Latency : SYNC_STAGES+1 clk from pin change to event pulse.
// Backpr. : none; events are pulses, the consumer must act in the same cycle.
// Ports   : clk, rst (async high); scl, sda pins in; sda_s synced data; scl_rise, scl_fall,
//           start_det, stop_det event pulses.
module i2c_bus_monitor #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  input  logic sda,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_q;
  logic                   sda_q;
  logic                   scl_s;

  // Reset to the idle bus level so leaving reset never looks like an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
      scl_q    <= scl_sync[SYNC_STAGES-1];
      sda_q    <= sda_sync[SYNC_STAGES-1];
    end
  end

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_q;
  assign scl_fall  = ~scl_s & scl_q;
  // SCL must be high in both samples so an SDA change at an SCL edge is not a bus condition.
  assign start_det = scl_s & scl_q & sda_q & ~sda_s;
  assign stop_det  = scl_s & scl_q & ~sda_q & sda_s;

endmodule

// File: rtl/mpu6050_i2c_target.sv
// Purpose : I2C target emulating the MPU6050 register view (gyro XYZ, PWR_MGMT_1, WHO_AM_I).
// Latency : SDA updates one clk after the synchronised SCL falling edge.
// Backpr. : never stretches SCL; every write byte is ACKed.
// Ports   : clk, rst (async high); scl in; sda open-drain inout; gyro_x/y/z samples in;
//           pwr_mgmt_1 register out; reg_wr write pulse; busy from address match to STOP.
// Build   : define MPU6050_SNAPSHOT_EN to freeze gyro data per read burst (no XH/XL tearing).
module mpu6050_i2c_target
  import mpu6050_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR     = 7'h68,
  parameter logic [7:0] WHO_AM_I_VAL = 8'h68,
  parameter int         SYNC_STAGES  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl,
  inout  wire         sda,
  input  logic [15:0] gyro_x,
  input  logic [15:0] gyro_y,
  input  logic [15:0] gyro_z,
  output logic [7:0]  pwr_mgmt_1,
  output logic        reg_wr,
  output logic        busy
);

  logic sda_s, scl_rise, scl_fall, start_det, stop_det;

  i2c_bus_monitor #(.SYNC_STAGES(SYNC_STAGES)) u_mon (
    .clk       (clk),
    .rst       (rst),
    .scl       (scl),
    .sda       (sda),
    .sda_s     (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  i2c_tgt_state_t state, state_n;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic [7:0] shreg, shreg_n;
  logic [7:0] ptr, ptr_n;
  logic [7:0] pwr_n;
  logic       sda_oe, sda_oe_n;
  logic       busy_n, reg_wr_n;
  logic       ack_half, ack_half_n;   // first SCL fall of an ACK bit already seen
  logic       mst_ack, mst_ack_n;
  logic       rw, rw_n;
  logic [47:0] gyro_src;
  logic [7:0]  byte_in;
  logic [7:0]  rd_val;
  logic        last_bit;

`ifdef MPU6050_SNAPSHOT_EN
  logic [47:0] snap, snap_n;
  assign gyro_src = snap;
`else
  assign gyro_src = {gyro_x, gyro_y, gyro_z};
`endif

  assign byte_in  = {shreg[6:0], sda_s};
  assign last_bit = (bit_cnt == 3'd7);
  assign rd_val   = reg_read(ptr, gyro_src, pwr_mgmt_1, WHO_AM_I_VAL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= 3'd0;
      shreg      <= 8'h00;
      ptr        <= 8'h00;
      pwr_mgmt_1 <= PWR_MGMT_1_RST;
      sda_oe     <= 1'b0;
      busy       <= 1'b0;
      reg_wr     <= 1'b0;
      ack_half   <= 1'b0;
      mst_ack    <= 1'b0;
      rw         <= 1'b0;
`ifdef MPU6050_SNAPSHOT_EN
      snap       <= 48'h0;
`endif
    end else begin
      state      <= state_n;
      bit_cnt    <= bit_cnt_n;
      shreg      <= shreg_n;
      ptr        <= ptr_n;
      pwr_mgmt_1 <= pwr_n;
      sda_oe     <= sda_oe_n;
      busy       <= busy_n;
      reg_wr     <= reg_wr_n;
      ack_half   <= ack_half_n;
      mst_ack    <= mst_ack_n;
      rw         <= rw_n;
`ifdef MPU6050_SNAPSHOT_EN
      snap       <= snap_n;
`endif
    end
  end

  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    shreg_n    = shreg;
    ptr_n      = ptr;
    pwr_n      = pwr_mgmt_1;
    sda_oe_n   = sda_oe;
    busy_n     = busy;
    reg_wr_n   = 1'b0;
    ack_half_n = ack_half;
    mst_ack_n  = mst_ack;
    rw_n       = rw;
`ifdef MPU6050_SNAPSHOT_EN
    snap_n     = snap;
`endif

    // Bus conditions override any bit activity in the same cycle.
    if (stop_det) begin
      state_n    = IDLE;
      busy_n     = 1'b0;
      sda_oe_n   = 1'b0;
      bit_cnt_n  = 3'd0;
      ack_half_n = 1'b0;
    end else if (start_det) begin
      state_n    = ADDR;
      sda_oe_n   = 1'b0;
      bit_cnt_n  = 3'd0;
      ack_half_n = 1'b0;
    end else begin
      case (state)
        ADDR, REG, WR_DATA: begin
          if (scl_rise) begin
            shreg_n   = byte_in;
            bit_cnt_n = bit_cnt + 3'd1;
            if (last_bit) begin
              ack_half_n = 1'b0;
              if (state == ADDR) begin
                if (byte_in[7:1] == DEV_ADDR) begin
                  state_n = ADDR_ACK;
                  busy_n  = 1'b1;
                  rw_n    = byte_in[0];
`ifdef MPU6050_SNAPSHOT_EN
                  if (byte_in[0]) snap_n = {gyro_x, gyro_y, gyro_z};
`endif
                end else begin
                  state_n = WAIT_STOP;
                end
              end else if (state == REG) begin
                ptr_n   = byte_in;
                state_n = REG_ACK;
              end else begin
                reg_wr_n = 1'b1;
                if (ptr == REG_PWR_MGMT_1) pwr_n = byte_in;
                ptr_n   = ptr + 8'd1;
                state_n = WR_ACK;
              end
            end
          end
        end

        // Target ACK: pull low on the first fall, release on the fall that ends the bit.
        ADDR_ACK, REG_ACK, WR_ACK: begin
          if (scl_fall) begin
            if (!ack_half) begin
              sda_oe_n   = 1'b1;
              ack_half_n = 1'b1;
            end else begin
              sda_oe_n   = 1'b0;
              ack_half_n = 1'b0;
              if (state == ADDR_ACK && rw) begin
                state_n  = RD_DATA;
                shreg_n  = rd_val;
                sda_oe_n = ~rd_val[7];
              end else if (state == ADDR_ACK) begin
                state_n = REG;
              end else begin
                state_n = WR_DATA;
              end
            end
          end
        end

        RD_DATA: begin
          if (scl_rise) begin
            bit_cnt_n = bit_cnt + 3'd1;
            if (last_bit) begin
              state_n    = RD_ACK;
              ack_half_n = 1'b0;
            end
          end else if (scl_fall) begin
            shreg_n  = {shreg[6:0], 1'b0};
            sda_oe_n = ~shreg[6];
          end
        end

        RD_ACK: begin
          if (scl_rise && ack_half) begin
            mst_ack_n = ~sda_s;
            if (!sda_s) ptr_n = ptr + 8'd1;
          end else if (scl_fall) begin
            if (!ack_half) begin
              sda_oe_n   = 1'b0;
              ack_half_n = 1'b1;
            end else begin
              ack_half_n = 1'b0;
              if (mst_ack) begin
                state_n  = RD_DATA;
                shreg_n  = rd_val;
                sda_oe_n = ~rd_val[7];
              end else begin
                state_n = WAIT_STOP;
              end
            end
          end
        end

        default: ;
      endcase
    end
  end

  assign sda = sda_oe ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_mpu6050_i2c_target.sv
// Purpose : directed + randomized bus-level bench for mpu6050_i2c_target with a register-map model.
// Latency : n/a.
// Backpr. : n/a.
module tb_mpu6050_i2c_target;

  localparam int QCLK = 10;  // clk cycles per quarter SCL period (SCL = clk/40)

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m_scl = 1'b1;
  logic        m_sda_low = 1'b0;
  logic [15:0] gyro_x = 16'h0, gyro_y = 16'h0, gyro_z = 16'h0;
  logic [7:0]  pwr_mgmt_1;
  logic        reg_wr, busy;
  wire         sda;

  pullup (sda);
  assign sda = m_sda_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  mpu6050_i2c_target dut (
    .clk        (clk),
    .rst        (rst),
    .scl        (m_scl),
    .sda        (sda),
    .gyro_x     (gyro_x),
    .gyro_y     (gyro_y),
    .gyro_z     (gyro_z),
    .pwr_mgmt_1 (pwr_mgmt_1),
    .reg_wr     (reg_wr),
    .busy       (busy)
  );

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int tgt_low_cnt = 0;

  // Reference state of the register model.
  logic [7:0]  model_ptr = 8'h00;
  logic [7:0]  model_pwr = 8'h40;
  logic [15:0] snap_x, snap_y, snap_z;

  always @(negedge clk) begin
    if (reg_wr) wr_cnt++;
    if (sda === 1'b0 && !m_sda_low) tgt_low_cnt++;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_byte(input logic [7:0] a, input logic [15:0] x,
                                          input logic [15:0] y, input logic [15:0] z,
                                          input logic [7:0] pwr);
    logic [47:0] g;
    g = {x, y, z};
    if (a >= 8'h43 && a <= 8'h48) return 8'((g >> (8 * (8'h48 - a))) & 48'hFF);
    if (a == 8'h6B) return pwr;
    if (a == 8'h75) return 8'h68;
    return 8'h00;
  endfunction

  task automatic q();
    repeat (QCLK) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_sda_low = 1'b0; q();
    m_scl = 1'b1;     q();
    m_sda_low = 1'b1; q();
    m_scl = 1'b0;     q();
  endtask

  task automatic i2c_stop();
    m_sda_low = 1'b1; q();
    m_scl = 1'b1;     q();
    m_sda_low = 1'b0; q();
  endtask

  task automatic send_bit(input logic b);
    m_sda_low = ~b; q();
    m_scl = 1'b1;   q(); q();
    m_scl = 1'b0;   q();
  endtask

  task automatic wr_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    m_sda_low = 1'b0; q();
    m_scl = 1'b1;     q();
    ack = (sda === 1'b0);
    q();
    m_scl = 1'b0;     q();
  endtask

  task automatic rd_bits(output logic [7:0] b);
    m_sda_low = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      q();
      m_scl = 1'b1; q();
      b[i] = (sda !== 1'b0);
      q();
      m_scl = 1'b0;
    end
    q();
  endtask

  task automatic rd_ack(input logic ack);
    m_sda_low = ack; q();
    m_scl = 1'b1;    q(); q();
    m_scl = 1'b0;    q();
    m_sda_low = 1'b0;
  endtask

  // Leaves the bus with SCL low right after the register-byte ACK.
  task automatic set_ptr(input logic [7:0] p);
    logic ack;
    i2c_start();
    wr_byte(8'hD0, ack); chk("addr_w_ack", 16'(ack), 16'h1);
    wr_byte(p, ack);     chk("reg_ack", 16'(ack), 16'h1);
    model_ptr = p;
  endtask

  task automatic read_burst(input logic [7:0] p, input int n);
    logic       ack;
    logic [7:0] b;
    set_ptr(p);
    i2c_start();
    wr_byte(8'hD1, ack); chk("addr_r_ack", 16'(ack), 16'h1);
    chk("busy_in_read", 16'(busy), 16'h1);
    snap_x = gyro_x; snap_y = gyro_y; snap_z = gyro_z;
    for (int i = 0; i < n; i++) begin
      rd_bits(b);
      chk("rd_byte", {model_ptr, b},
          {model_ptr, ref_byte(model_ptr, snap_x, snap_y, snap_z, model_pwr)});
      if (i < n - 1) begin
        rd_ack(1'b1);
        model_ptr = model_ptr + 8'd1;
      end else begin
        rd_ack(1'b0);
      end
    end
    i2c_stop();
    chk("busy_after_stop", 16'(busy), 16'h0);
  endtask

  task automatic write_reg(input logic [7:0] p, input logic [7:0] v);
    logic ack;
    int   w0;
    w0 = wr_cnt;
    set_ptr(p);
    wr_byte(v, ack); chk("wr_data_ack", 16'(ack), 16'h1);
    if (p == 8'h6B) model_pwr = v;
    model_ptr = model_ptr + 8'd1;
    i2c_stop();
    chk("reg_wr_pulses", 16'(wr_cnt - w0), 16'h1);
    chk("pwr_mgmt_1", 16'(pwr_mgmt_1), 16'(model_pwr));
  endtask

  initial begin
    logic       ack;
    logic [7:0] b;
    logic [7:0] exp_b;
    logic [7:0] starts [0:9];
    int         low0;

    starts = '{8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'h6B, 8'h75, 8'hFF, 8'h00};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_sda", 16'(sda), 16'h1);
    chk("rst_pwr", 16'(pwr_mgmt_1), 16'h40);
    chk("rst_busy", 16'(busy), 16'h0);
    chk("rst_reg_wr", 16'(reg_wr), 16'h0);
    rst = 1'b0;
    q();

    // 1: burst read XH, XL
    gyro_x = 16'h1234; gyro_y = 16'(($urandom)); gyro_z = 16'(($urandom));
    read_burst(8'h43, 2);

    // 2: WHO_AM_I, unmapped, pointer wrap
    read_burst(8'h75, 1);
    read_burst(8'h10, 1);
    read_burst(8'hFF, 2);

    // 3: writes
    write_reg(8'h6B, 8'h01);
    write_reg(8'h20, 8'h55);
    read_burst(8'h6B, 1);

    // 4: foreign address never ACKed or driven
    low0 = tgt_low_cnt;
    i2c_start();
    wr_byte(8'hA0, ack); chk("bad_addr_nack", 16'(ack), 16'h0);
    chk("bad_addr_busy", 16'(busy), 16'h0);
    wr_byte(8'h43, ack); chk("bad_addr_data_nack", 16'(ack), 16'h0);
    i2c_stop();
    chk("bad_addr_no_drive", 16'(tgt_low_cnt - low0), 16'h0);
    read_burst(8'h75, 1);

    // 5a: reset while the target drives the first read bit low (0x12 MSB = 0)
    gyro_x = 16'h1234;
    set_ptr(8'h43);
    i2c_start();
    wr_byte(8'hD1, ack); chk("mid_rst_addr_ack", 16'(ack), 16'h1);
    chk("mid_rst_driving", 16'(sda), 16'h0);
    rst = 1'b1;
    #1;
    chk("mid_rst_sda_released", 16'(sda), 16'h1);
    @(negedge clk);
    chk("mid_rst_pwr", 16'(pwr_mgmt_1), 16'h40);
    chk("mid_rst_busy", 16'(busy), 16'h0);
    m_scl = 1'b1; m_sda_low = 1'b0;
    q();
    rst = 1'b0;
    model_pwr = 8'h40; model_ptr = 8'h00;
    q();
    read_burst(8'h43, 2);

    // 5b: STOP in the middle of a register byte
    i2c_start();
    wr_byte(8'hD0, ack); chk("mid_stop_addr_ack", 16'(ack), 16'h1);
    chk("mid_stop_busy_before", 16'(busy), 16'h1);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    i2c_stop();
    chk("mid_stop_busy_after", 16'(busy), 16'h0);
    read_burst(8'h75, 1);

    // 6: gyro_x changes between XH and XL of one burst
    gyro_x = 16'h1234;
    set_ptr(8'h43);
    i2c_start();
    wr_byte(8'hD1, ack); chk("tear_addr_ack", 16'(ack), 16'h1);
    rd_bits(b); chk("tear_xh", 16'(b), 16'h12);
    gyro_x = 16'hABCD;
    rd_ack(1'b1);
    rd_bits(b);
`ifdef MPU6050_SNAPSHOT_EN
    exp_b = 8'h34;
`else
    exp_b = 8'hCD;
`endif
    chk("tear_xl", 16'(b), 16'(exp_b));
    rd_ack(1'b0);
    i2c_stop();

    // Randomized bursts and PWR_MGMT_1 writes against the model
    for (int it = 0; it < 8; it++) begin
      gyro_x = 16'($urandom); gyro_y = 16'($urandom); gyro_z = 16'($urandom);
      if (it % 3 == 2) begin
        write_reg(8'h6B, 8'($urandom));
      end else begin
        b = starts[$urandom_range(0, 9)];
        if (b == 8'h00) b = 8'($urandom);
        read_burst(b, int'($urandom_range(1, 3)));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
